// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared state type, SRAM layout and width
// helpers for the cross-correlation sequencer.
package xcorr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_G,
    CALC,
    CMP,
    DONE
  } state_t;

  // f occupies the bottom of the SRAM, g sits right above it
  localparam int F_BASE = 0;

  function automatic int g_base(input int f_len);
    return F_BASE + f_len;
  endfunction

  function automatic int accw(input int dw, input int g_len);
    return 2 * dw + $clog2(g_len);
  endfunction

  function automatic int lw(input int f_len, input int g_len);
    int p;
    p = f_len - g_len;
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/xcorr_sched_if.sv
// xcorr_sched_if: single-port SRAM read channel between
// the sequencer (master) and the sample memory (slave).
interface xcorr_sched_if #(
  parameter int DW = 8,
  parameter int AW = 11
);
  logic                 sram_en;
  logic [AW-1:0]        sram_addr;
  logic signed [DW-1:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_addr,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_addr,
    output sram_rdata
  );
endinterface

// File: rtl/xcorr_sched_mac.sv
// xcorr_mac: signed DW x DW multiply feeding a
// sign-extended ACCW accumulator with clear and enable.
module xcorr_mac #(
  parameter int DW   = 8,
  parameter int ACCW = 22
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/xcorr_sched.sv
// xcorr_sched: loads g, sweeps a MAC window over every
// lag of f, and tracks the maximum correlation and its lag.
module xcorr_sched
  import xcorr_pkg::*;
#(
  parameter int F_LEN = 1024,
  parameter int G_LEN = 64,
  parameter int DW    = 8,
  parameter int AW    = 11
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  xcorr_sched_if.master       sram,
  output logic signed [accw(DW, G_LEN)-1:0] max_value,
  output logic [lw(F_LEN, G_LEN)-1:0]       max_loc
);

  localparam int P    = F_LEN - G_LEN;
  localparam int ACCW = accw(DW, G_LEN);
  localparam int LW   = lw(F_LEN, G_LEN);
  localparam int JW   = (G_LEN > 1) ? $clog2(G_LEN) : 1;

  localparam logic [AW-1:0] G_ADDR = AW'(g_base(F_LEN));
  localparam logic [AW-1:0] F_ADDR = AW'(F_BASE);
  localparam logic [JW-1:0] J_LAST = JW'(G_LEN - 1);
  localparam logic [LW-1:0] K_LAST = LW'(P - 1);

  state_t state, state_n;

  logic          en, en_n;
  logic [AW-1:0] addr, addr_n;
  logic [JW-1:0] j, j_n;
  logic [JW-1:0] cj;
  logic [LW-1:0] k, k_n;
  logic          vld;
  logic          last_data;
  logic          take;
  logic          mac_clr;
  logic          mac_en;

  logic signed [DW-1:0]   g_reg [G_LEN];
  logic signed [ACCW-1:0] acc;

  // vld/cj describe the sample arriving this cycle
  assign last_data = vld && (cj == J_LAST);

  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    addr_n  = addr;
    j_n     = j;
    k_n     = k;
    take    = 1'b0;

    if (en && (j != J_LAST)) begin
      en_n   = 1'b1;
      j_n    = j + 1'b1;
      addr_n = addr + 1'b1;
    end

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LOAD_G;
          en_n    = 1'b1;
          addr_n  = G_ADDR;
          j_n     = '0;
          k_n     = '0;
        end
      end
      LOAD_G: begin
        if (last_data) begin
          state_n = CALC;
          en_n    = 1'b1;
          addr_n  = F_ADDR;
          j_n     = '0;
        end
      end
      CALC: begin
        if (last_data) begin
          state_n = CMP;
        end
      end
      CMP: begin
        take = (k == '0) || (acc > max_value);
        if (k == K_LAST) begin
          state_n = DONE;
        end else begin
          state_n = CALC;
          k_n     = k + 1'b1;
          en_n    = 1'b1;
          addr_n  = F_ADDR + AW'(k) + 1'b1;
          j_n     = '0;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      en        <= 1'b0;
      addr      <= '0;
      j         <= '0;
      k         <= '0;
      vld       <= 1'b0;
      cj        <= '0;
      max_value <= '0;
      max_loc   <= '0;
    end else begin
      state <= state_n;
      en    <= en_n;
      addr  <= addr_n;
      j     <= j_n;
      k     <= k_n;
      vld   <= en;
      cj    <= j;
      if (take) begin
        max_value <= acc;
        max_loc   <= k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld && (state == LOAD_G)) begin
      g_reg[cj] <= sram.sram_rdata;
    end
  end

  // acc is held through CMP and cleared outside CALC
  assign mac_clr = (state != CALC);
  assign mac_en  = vld && (state == CALC);

  xcorr_mac #(
    .DW  (DW),
    .ACCW(ACCW)
  ) u_mac (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (sram.sram_rdata),
    .b      (g_reg[cj]),
    .acc    (acc)
  );

  assign busy = (state == LOAD_G) || (state == CALC) ||
                (state == CMP);
  assign done = (state == DONE);

  assign sram.sram_en   = en;
  assign sram.sram_addr = addr;

endmodule

// File: tb/tb_xcorr_sched.sv
// tb_xcorr_sched: directed and randomized runs of the
// sequencer against a lag-by-lag reference correlation.
module tb_xcorr_sched;

  localparam int SF = 8;
  localparam int SG = 4;
  localparam int ST = 30;
  localparam int BF = 1024;
  localparam int BG = 64;
  localparam int BT = 63426;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_s = 1'b0;
  logic start_b = 1'b0;

  logic busy_s, done_s, busy_b, done_b;
  logic signed [17:0] maxv_s;
  logic [1:0]         loc_s;
  logic signed [21:0] maxv_b;
  logic [9:0]         loc_b;

  logic signed [7:0] mem_s [2048];
  logic signed [7:0] mem_b [2048];

  int checks = 0;
  int errors = 0;
  int trace[$];
  bit rec = 1'b0;

  xcorr_sched_if #(.DW(8), .AW(11)) sif_s ();
  xcorr_sched_if #(.DW(8), .AW(11)) sif_b ();

  always #5 clk = ~clk;

  xcorr_sched #(
    .F_LEN(SF), .G_LEN(SG), .DW(8), .AW(11)
  ) dut_s (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_s),
    .busy     (busy_s),
    .done     (done_s),
    .sram     (sif_s),
    .max_value(maxv_s),
    .max_loc  (loc_s)
  );

  xcorr_sched #(
    .F_LEN(BF), .G_LEN(BG), .DW(8), .AW(11)
  ) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start_b),
    .busy     (busy_b),
    .done     (done_b),
    .sram     (sif_b),
    .max_value(maxv_b),
    .max_loc  (loc_b)
  );

  always @(posedge clk) begin
    if (sif_s.sram_en) sif_s.sram_rdata <= mem_s[sif_s.sram_addr];
  end

  always @(posedge clk) begin
    if (sif_b.sram_en) sif_b.sram_rdata <= mem_b[sif_b.sram_addr];
  end

  always @(posedge clk) begin
    if (rec && sif_s.sram_en) trace.push_back(int'(sif_s.sram_addr));
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // straight definition: every lag's dot product, first strict max wins
  function automatic void model_s(output longint mv, output longint ml);
    longint s;
    mv = 0;
    ml = 0;
    for (int k = 0; k < SF - SG; k++) begin
      s = 0;
      for (int j = 0; j < SG; j++)
        s += longint'(mem_s[k + j]) * longint'(mem_s[SF + j]);
      if (k == 0 || s > mv) begin
        mv = s;
        ml = k;
      end
    end
  endfunction

  task automatic fill(input int kind);
    int v;
    for (int i = 0; i < SF + SG; i++) begin
      if (kind == 0) v = (i < SF) ? i : 1;
      else if (kind == 1) v = 1;
      else if (kind == 2) v = (i < SF) ? 1 : -(i - SF + 1);
      else if (kind == 3) v = -128;
      else if (kind == 4) v = int'($urandom_range(0, 255)) - 128;
      else v = int'($urandom_range(0, 4)) - 2;
      mem_s[i] = 8'(v);
    end
  endtask

  task automatic run_s(input bit rep, output int n);
    trace.delete();
    rec = 1'b1;
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    n = 1;
    while (!done_s && n < 200) begin
      start_s = rep ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1 n++;
    end
    start_s = 1'b0;
    rec = 1'b0;
  endtask

  task automatic chk_trace(input string tag);
    int want[$];
    int bad;
    bad = 0;
    for (int j = 0; j < SG; j++) want.push_back(SF + j);
    for (int k = 0; k < SF - SG; k++)
      for (int j = 0; j < SG; j++) want.push_back(k + j);
    chk({tag, "_reads"}, trace.size(), want.size());
    for (int i = 0; i < want.size() && i < trace.size(); i++)
      if (trace[i] != want[i]) bad++;
    chk({tag, "_addr"}, bad, 0);
  endtask

  task automatic chk_model(input string tag, input int n);
    longint mv, ml;
    model_s(mv, ml);
    chk({tag, "_cyc"}, n, ST);
    chk({tag, "_max"}, maxv_s, mv);
    chk({tag, "_loc"}, loc_s, ml);
  endtask

  initial begin
    int n;
    int cnt;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_en", sif_s.sram_en, 0);
    chk("rst_addr", sif_s.sram_addr, 0);
    chk("rst_max", maxv_s, 0);
    chk("rst_loc", loc_s, 0);
    chk("rst_b_done", done_b, 0);
    chk("rst_b_en", sif_b.sram_en, 0);
    reset_n = 1'b1;

    fill(0);
    run_s(1'b0, n);
    chk("ramp_cyc", n, ST);
    chk("ramp_max", maxv_s, 18);
    chk("ramp_loc", loc_s, 3);
    chk("ramp_busy", busy_s, 0);
    chk_trace("ramp");

    fill(1);
    run_s(1'b0, n);
    chk("tie_max", maxv_s, 4);
    chk("tie_loc", loc_s, 0);

    fill(2);
    run_s(1'b0, n);
    chk("neg_max", maxv_s, -10);
    chk("neg_loc", loc_s, 0);

    fill(3);
    run_s(1'b0, n);
    chk("ext_max", maxv_s, 65536);
    chk("ext_loc", loc_s, 0);

    for (int r = 0; r < 6; r++) begin
      fill((r % 2 == 0) ? 4 : 5);
      run_s(1'b0, n);
      chk_model("rand", n);
    end

    fill(4);
    run_s(1'b1, n);
    chk_model("restart_busy", n);
    chk_trace("restart_busy");

    fill(5);
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    chk("redone_done", done_s, 0);
    chk("redone_busy", busy_s, 1);
    n = 1;
    while (!done_s && n < 200) begin
      @(posedge clk); #1 n++;
    end
    chk_model("redone", n);

    fill(0);
    @(posedge clk); #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    n = 1;
    while (n < 19) begin
      @(posedge clk); #1 n++;
    end
    chk("mid_busy", busy_s, 1);
    chk("mid_max", maxv_s, 10);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", busy_s, 0);
    chk("mid_rst_done", done_s, 0);
    chk("mid_rst_en", sif_s.sram_en, 0);
    chk("mid_rst_addr", sif_s.sram_addr, 0);
    chk("mid_rst_max", maxv_s, 0);
    chk("mid_rst_loc", loc_s, 0);
    reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (sif_s.sram_en) cnt++;
    end
    chk("mid_quiet_en", cnt, 0);
    chk("mid_idle_done", done_s, 0);
    run_s(1'b0, n);
    chk("post_cyc", n, ST);
    chk("post_max", maxv_s, 18);
    chk("post_loc", loc_s, 3);

    for (int i = 0; i < BF + BG; i++) mem_b[i] = 8'sh80;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 1;
    while (!done_b && n < 70000) begin
      @(posedge clk); #1 n++;
    end
    chk("big_cyc", n, BT);
    chk("big_max", maxv_b, 1048576);
    chk("big_loc", loc_b, 0);
    chk("big_busy", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcorr_sched.md
# xcorr_sched

Sequencer for the cross-correlation engine. It reads a reference sequence g and a long sequence f from a single-port synchronous SRAM, steps a multiply-accumulate window across every lag, and keeps the maximum correlation value and its lag. It sits between the top-level controller (start/done handshake) and the sample SRAM, and its results feed the LCD text formatter.

## Interface
Parameters:
- F_LEN, 1024, number of f samples, stored at SRAM addresses 0..F_LEN-1.
- G_LEN, 64, number of g samples, stored at SRAM addresses F_LEN..F_LEN+G_LEN-1.
- DW, 8, sample width (signed two's complement).
- AW, 11, SRAM address width; must satisfy 2^AW >= F_LEN+G_LEN.
- Derived, not overridable: P = F_LEN-G_LEN lags; ACCW = 2*DW+$clog2(G_LEN); LW = $clog2(P).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a run; ignored unless the block is in IDLE or DONE
- busy  out  1  high from the cycle after start is accepted until done rises
- done  out  1  level; high from run completion until the next accepted start
- sram_en  out  1  SRAM read enable
- sram_addr  out  AW  SRAM read address
- sram_rdata  in  DW  read data, valid exactly 1 cycle after sram_en
- max_value  out  ACCW  signed maximum correlation; 22 bits with default parameters
- max_loc  out  LW  lag at which max_value occurred; 10 bits with default parameters

## Operation
- States: IDLE, LOAD_G, CALC, CMP, DONE.
- IDLE / DONE, start=1 -> LOAD_G. Entering LOAD_G clears done and the internal counters; max_value and max_loc keep their old values until the first CMP.
- LOAD_G:
  - Issue G_LEN reads at addresses F_LEN+j, j = 0..G_LEN-1.
  - Capture each returned sample into the g register file g_reg[j].
  - After the last capture -> CALC with lag k=0.
- CALC (lag k):
  - Issue G_LEN reads at addresses k+j.
  - Accumulate acc += sram_rdata * g_reg[j] as a signed product, sign-extended to ACCW. The accumulator cannot overflow.
  - acc is cleared at the start of each lag.
  - After the last accumulate -> CMP.
- CMP:
  - If k==0 or acc > max_value (signed, strict), load max_value=acc and max_loc=k. Ties therefore keep the earliest lag.
  - If k==P-1 -> DONE; otherwise k++ and return to CALC.
- DONE: hold the results and assert done until the next start.
- start while busy: ignored, with no effect on the current run.
- Reset, including mid-run: state=IDLE on the next edge; all outputs return to their reset values; no SRAM reads are issued afterwards.

## Timing
- Reset values: busy=0, done=0, sram_en=0, sram_addr=0, max_value=0, max_loc=0.
- start is sampled in cycle 0, and LOAD_G's first read is issued in cycle 1.
- sram_en is high only on cycles that issue a read. sram_addr is registered alongside sram_en.
- LOAD_G takes G_LEN+1 cycles: G_LEN issue cycles, with the last data captured one cycle later.
- Each lag takes G_LEN+2 cycles:
  - CALC: G_LEN issue cycles plus 1 drain cycle.
  - CMP: 1 cycle.
  - sram_en is low during the drain and CMP cycles.
- done rises, and busy falls, T = (G_LEN+1) + P*(G_LEN+2) + 1 cycles after start is sampled. With default parameters T = 63426.
- max_value and max_loc are stable whenever done=1.

## Structure
- Shared package xcorr_pkg:
  - state enum.
  - SRAM base-address constants F_BASE and G_BASE.
  - the ACCW and LW width functions.
- One sub-module, xcorr_mac: signed DW x DW multiply plus ACCW accumulator, with clear and enable inputs. The FSM, address counters, g register file and max tracker stay in xcorr_sched.
- The SRAM model is bench-only and has 1-cycle read latency.

## Test plan
All scenarios use F_LEN=8, G_LEN=4, so P=4 and T=30.
- Ramp: f=0..7, g=1,1,1,1 -> lag sums 6, 10, 14, 18; expect max_value=18, max_loc=3, done exactly 30 cycles after start.
- Tie: f all 1, g all 1 -> every lag sums to 4; expect max_value=4, max_loc=0 (earliest lag wins).
- All negative: f all 1, g=-1,-2,-3,-4 -> every lag -10; expect max_value=-10, max_loc=0 (lag 0 is loaded unconditionally, so a negative maximum is reported).
- Extremes: f all -128, g all -128 -> expect max_value=65536, with no overflow. Repeat with default parameters: expect 1048576, which fits in 22 bits signed.
- Handshake: start asserted repeatedly during the run -> result identical to a single start. start asserted in DONE -> done drops the next cycle and a fresh run completes after T cycles.
- Reset mid-run: assert reset_n=0 during CALC of lag 2 -> next cycle all outputs are 0, state IDLE, sram_en stays low. A subsequent start gives correct results.
